pair_monitor: RTL
=================

Name: pair_monitor

Overview:
- Downstream consumer of the generic data/inverse stage.
- Each valid cycle it samples the stage's data word and inverse word, checks that the inverse is the bitwise complement of the data, and tags the word with an error bit.
- Tagged words are queued in a small FIFO that a valid/ready sink drains.
- It keeps saturating statistics and detects the producer's terminal all-ones pattern to declare end-of-run.

Parameters:
- N, 4, data word width (matches producer N).
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- DONE_HOLD, 3, consecutive all-ones valid samples needed to declare done; >= 1.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the clk rising edge only.
- clear  input  1  synchronous restart pulse; accepted only in DONE.
- in_valid  input  1  in_data/in_inv qualify this cycle.
- in_data  input  N  producer data word (dout).
- in_inv  input  N  producer inverse word (inversa).
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  sink accepts head.
- out_data  output  N  FIFO head data.
- out_err  output  1  FIFO head error tag.
- sample_count  output  8  accepted samples, saturates at 255.
- err_count  output  8  mismatching samples, saturates at 255.
- drop_count  output  8  samples lost to a full FIFO, saturates at 255.
- done  output  1  high while in DONE.
- busy  output  1  high in COLLECT.

Behaviour:
- Reset (rst=0 at a clk edge) forces:
  - state=IDLE, FIFO empty (pointers 0), out_valid=0, out_data=0, out_err=0;
  - all counters 0, done=0, busy=0, ones-run counter 0.
  - Reset mid-operation discards FIFO contents and stats; there is no partial behaviour.
- State IDLE:
  - in_valid=1 moves to COLLECT.
  - That same sample is processed exactly as in COLLECT; no sample is lost on entry.
- State COLLECT, each cycle with in_valid=1:
  - err = (in_inv != ~in_data).
  - Push {in_data, err} when the FIFO is not full, or when it is full but a pop occurs the same cycle.
  - If pushed, sample_count+1; otherwise drop_count+1. A dropped sample is still counted in err_count if erroneous.
  - err_count+1 when err=1.
  - Ones-run counter: +1 if in_data is all ones, else reset to 0.
  - When the ones-run reaches DONE_HOLD (including the current sample), go to DONE next cycle.
  - A cycle with in_valid=0 leaves the ones-run unchanged.
- State DONE:
  - in_valid is ignored; no pushes, no counter changes.
  - The FIFO keeps draining.
  - clear=1 returns to IDLE: counters, ones-run and FIFO are all zeroed. The drain in that cycle is lost.
  - clear outside DONE has no effect.
- FIFO:
  - Registered outputs; out_data/out_err/out_valid reflect the head.
  - Pop when out_valid & out_ready.
  - Push-to-out_valid latency is 1 cycle; out_valid rises the cycle after the first push into an empty FIFO.
  - Push and pop in the same cycle when empty: push then visible next cycle. No bypass.
  - Pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.
- Saturation: counters hold at 255 and never wrap.
- Outputs busy/done are decoded from registered state only.

Decomposition:
- Shared package holds:
  - the state enum (IDLE=2'b00, COLLECT=2'b01, DONE=2'b10), matching the producer's encoding;
  - the counter width constant CNT_W=8.
- Sub-module: pair_fifo (parameters N+1 width, DEPTH).
  - Synchronous active-low reset.
  - push/pop/full/empty plus registered head.
- The monitor instantiates one pair_fifo and owns the FSM, checks and counters.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> all outputs 0, state IDLE, no push.
- Clean stream, N=4, out_ready=1, in_data=3,5,9 with in_inv=C,A,6 -> out_data 3,5,9 each with out_err=0, one cycle after each push; sample_count=3, err_count=0.
- Mismatch: in_data=4, in_inv=4 -> out_err=1, err_count=1, word still queued.
- Overflow, DEPTH=4, out_ready=0, 6 valid samples -> out_valid=1, sample_count=4, drop_count=2. Then out_ready=1 drains exactly the first 4 words in order.
- Full with simultaneous pop: full FIFO, out_ready=1 and in_valid=1 in the same cycle -> push accepted, drop_count unchanged.
- Done detection, DONE_HOLD=3: in_data=F,F,2,F,F,F (inv=0) -> done asserts the cycle after the 6th sample. A further sample is ignored (sample_count=6). Then clear=1 -> IDLE, counters 0, FIFO empty.

Source files
------------

// File: rtl/pair_monitor_pkg.sv
// pair_monitor_pkg: shared state encoding, counter width and saturating increment
package pair_monitor_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, COLLECT = 2'b01, DONE = 2'b10} state_t;
    localparam int CNT_W = 8;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && c != '1) ? c + CNT_W'(1) : c;
    endfunction
endpackage

// File: rtl/pair_monitor_fifo.sv
// pair_fifo: small FIFO with a registered head word and an extra pointer bit for full/empty
module pair_fifo #(
    parameter int W = 5,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic         full,
    output logic         valid,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wr, rd, wr_n, rd_n;
    assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign wr_n = wr + (AW+1)'(push);
    assign rd_n = rd + (AW+1)'(pop);
    always_ff @(posedge clk)
        if (push) mem[wr[AW-1:0]] <= wdata;
    // the head register loads the incoming word when it lands in the head slot
    always_ff @(posedge clk)
        if (!rst || flush) begin
            {wr, rd, valid, head} <= '0;
        end else begin
            wr <= wr_n;
            rd <= rd_n;
            valid <= wr_n != rd_n;
            head <= (wr_n == rd_n) ? '0 :
                    (push && rd_n[AW-1:0] == wr[AW-1:0]) ? wdata : mem[rd_n[AW-1:0]];
        end
endmodule

// File: rtl/pair_monitor.sv
// pair_monitor: checks data/inverse pairs, queues tagged words, keeps stats and detects end-of-run
module pair_monitor
    import pair_monitor_pkg::*;
#(
    parameter int N = 4,
    parameter int DEPTH = 4,
    parameter int DONE_HOLD = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    input  logic [N-1:0]     in_inv,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             done,
    output logic             busy
);
    localparam int OW = $clog2(DONE_HOLD + 1);
    state_t state;
    logic [OW-1:0] ones, ones_n;
    logic take, err, pop, push, full, hit, flush;
    assign take = in_valid && state != DONE;
    assign err = in_inv != ~in_data;
    assign pop = out_valid && out_ready;
    assign push = take && (!full || pop);
    assign ones_n = &in_data ? ones + OW'(1) : '0;
    assign hit = ones_n == OW'(DONE_HOLD);
    assign flush = state == DONE && clear;
    assign done = state == DONE;
    assign busy = state == COLLECT;
    pair_fifo #(.W(N + 1), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .push(push),
        .pop(pop),
        .wdata({in_data, err}),
        .full(full),
        .valid(out_valid),
        .head({out_data, out_err})
    );
    // IDLE processes its first sample exactly like COLLECT
    always_ff @(posedge clk)
        if (!rst || flush) begin
            state <= IDLE;
            {sample_count, err_count, drop_count} <= '0;
            ones <= '0;
        end else if (take) begin
            state <= hit ? DONE : COLLECT;
            sample_count <= sat_inc(sample_count, push);
            drop_count <= sat_inc(drop_count, !push);
            err_count <= sat_inc(err_count, err);
            ones <= ones_n;
        end
endmodule
